// File: rtl/gamma_replay_buffer.sv
// Ping-pong replay buffer: captures NUM_INPUTS channels per gamma cycle, replays the other bank over valid/ready (first word 2 edges after grst, held under !out_ready).
// Optional GAMMA_REPLAY_ZERO_SKIP_EN: all-zero words are consumed internally for one cycle each and never presented.
module gamma_replay_buffer #(
  parameter int NUM_INPUTS   = 2,
  parameter int BUFFER_DEPTH = 16,
  parameter int P            = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            grst,
  input  logic                            wr_en,
  input  logic [$clog2(BUFFER_DEPTH)-1:0] wr_idx,
  input  logic [NUM_INPUTS*P-1:0]         data_in,
  input  logic                            out_ready,
  output logic                            out_valid,
  output logic [P-1:0]                    out_data,
  output logic [$clog2(NUM_INPUTS)-1:0]   out_ch,
  output logic [$clog2(BUFFER_DEPTH)-1:0] out_idx,
  output logic                            replay_busy,
  output logic                            overrun
);

  localparam int IW = $clog2(BUFFER_DEPTH);
  localparam int CW = $clog2(NUM_INPUTS);
  localparam int FW = IW + 1;

`ifdef GAMMA_REPLAY_ZERO_SKIP_EN
  localparam bit ZERO_SKIP = 1'b1;
`else
  localparam bit ZERO_SKIP = 1'b0;
`endif

  typedef enum logic [0:0] {IDLE, REPLAY} state_t;

  logic [P-1:0] mem_q [2][BUFFER_DEPTH][NUM_INPUTS];

  logic [1:0][BUFFER_DEPTH-1:0] valid_q, valid_d;
  logic [FW-1:0]                fill_q [2];
  logic [FW-1:0]                fill_d [2];
  logic                         wsel_q, wsel_d;
  state_t                       state_q, state_d;
  logic [IW-1:0]                ptr_idx_q, ptr_idx_d;
  logic [CW-1:0]                ptr_ch_q, ptr_ch_d;
  logic                         ptr_done_q, ptr_done_d;
  logic                         out_valid_q, out_valid_d;
  logic [P-1:0]                 out_data_q, out_data_d;
  logic [CW-1:0]                out_ch_q, out_ch_d;
  logic [IW-1:0]                out_idx_q, out_idx_d;
  logic                         overrun_q, overrun_d;

  logic          rd_bank;
  logic [FW-1:0] rd_fill;
  logic [FW-1:0] wr_fill;
  logic [FW-1:0] swap_fill;
  logic [P-1:0]  rd_word;
  logic          fetch_last;

  assign rd_bank = ~wsel_q;
  assign rd_fill = fill_q[rd_bank];
  assign wr_fill = {1'b0, wr_idx} + FW'(1);
  // Fill the read bank will have after a swap, including a same-cycle write.
  assign swap_fill = (wr_en && (wr_fill > fill_q[wsel_q])) ? wr_fill : fill_q[wsel_q];
  assign rd_word = valid_q[rd_bank][ptr_idx_q] ? mem_q[rd_bank][ptr_idx_q][ptr_ch_q] : '0;
  assign fetch_last = ({1'b0, ptr_idx_q} == (rd_fill - FW'(1))) &&
                      (ptr_ch_q == CW'(NUM_INPUTS - 1));

  always_comb begin
    valid_d     = valid_q;
    fill_d      = fill_q;
    wsel_d      = wsel_q;
    state_d     = state_q;
    ptr_idx_d   = ptr_idx_q;
    ptr_ch_d    = ptr_ch_q;
    ptr_done_d  = ptr_done_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_idx_d   = out_idx_q;
    overrun_d   = overrun_q;

    if (wr_en) begin
      valid_d[wsel_q][wr_idx] = 1'b1;
      if (wr_fill > fill_q[wsel_q]) begin
        fill_d[wsel_q] = wr_fill;
      end
    end

    // The output register refills whenever it is empty or being accepted.
    if ((state_q == REPLAY) && (!out_valid_q || out_ready)) begin
      if (!ptr_done_q) begin
        if (ZERO_SKIP && (rd_word == '0)) begin
          out_valid_d = 1'b0;
        end else begin
          out_valid_d = 1'b1;
          out_data_d  = rd_word;
          out_ch_d    = ptr_ch_q;
          out_idx_d   = ptr_idx_q;
        end
        if (fetch_last) begin
          ptr_done_d = 1'b1;
        end
        if (ptr_ch_q == CW'(NUM_INPUTS - 1)) begin
          ptr_ch_d  = '0;
          ptr_idx_d = ptr_idx_q + IW'(1);
        end else begin
          ptr_ch_d = ptr_ch_q + CW'(1);
        end
      end else begin
        out_valid_d = 1'b0;
        state_d     = IDLE;
      end
    end

    if (grst) begin
      wsel_d          = ~wsel_q;
      valid_d[rd_bank] = '0;
      fill_d[rd_bank]  = '0;
      if (state_q == REPLAY) begin
        overrun_d   = 1'b1;
        out_valid_d = 1'b0;
      end
      if (swap_fill != '0) begin
        state_d    = REPLAY;
        ptr_idx_d  = '0;
        ptr_ch_d   = '0;
        ptr_done_d = 1'b0;
      end else begin
        state_d = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      fill_q[0]   <= '0;
      fill_q[1]   <= '0;
      wsel_q      <= 1'b0;
      state_q     <= IDLE;
      ptr_idx_q   <= '0;
      ptr_ch_q    <= '0;
      ptr_done_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_idx_q   <= '0;
      overrun_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      fill_q      <= fill_d;
      wsel_q      <= wsel_d;
      state_q     <= state_d;
      ptr_idx_q   <= ptr_idx_d;
      ptr_ch_q    <= ptr_ch_d;
      ptr_done_q  <= ptr_done_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_idx_q   <= out_idx_d;
      overrun_q   <= overrun_d;
    end
  end

  // Storage carries no reset; the valid map decides what replays as data.
  always_ff @(posedge clk) begin
    if (!rst && wr_en) begin
      for (int c = 0; c < NUM_INPUTS; c++) begin
        mem_q[wsel_q][wr_idx][c] <= data_in[c*P +: P];
      end
    end
  end

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_ch      = out_ch_q;
  assign out_idx     = out_idx_q;
  assign replay_busy = (state_q == REPLAY);
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_gamma_replay_buffer.sv
// Directed bench for gamma_replay_buffer with a scoreboard of expected replay words.
module tb_gamma_replay_buffer;

  logic         clk = 1'b0;
  logic         rst, grst, wr_en, out_ready;
  logic [3:0]   wr_idx;
  logic [127:0] data_in;
  logic         out_valid, replay_busy, overrun;
  logic [63:0]  out_data;
  logic [0:0]   out_ch;
  logic [3:0]   out_idx;

  gamma_replay_buffer #(.NUM_INPUTS(2), .BUFFER_DEPTH(16), .P(64)) dut (
    .clk(clk), .rst(rst), .grst(grst), .wr_en(wr_en), .wr_idx(wr_idx),
    .data_in(data_in), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ch(out_ch), .out_idx(out_idx),
    .replay_busy(replay_busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] d;
    int          ch;
    int          idx;
  } exp_t;

  exp_t sb[$];
  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] d, input int ch, input int idx);
    exp_t e;
`ifdef GAMMA_REPLAY_ZERO_SKIP_EN
    if (d == 64'h0) return;
`endif
    e.d = d; e.ch = ch; e.idx = idx;
    sb.push_back(e);
  endtask

  task automatic wr(input int idx, input logic [63:0] d0, input logic [63:0] d1);
    wr_en   = 1'b1;
    wr_idx  = 4'(idx);
    data_in = {d1, d0};
    tick();
    wr_en   = 1'b0;
  endtask

  // Consume words until the scoreboard is empty and the DUT is idle; bp selects ready pattern 1,0,0,1.
  task automatic drain(input int budget, input bit bp);
    int          cyc;
    int          ph;
    bit          stalled;
    logic [63:0] h_data;
    logic [63:0] h_ch;
    logic [63:0] h_idx;
    bit          pat [4];
    exp_t        e;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    cyc = 0; ph = 0; stalled = 1'b0;
    h_data = '0; h_ch = '0; h_idx = '0;
    while (((sb.size() > 0) || out_valid) && (cyc < budget)) begin
      out_ready = bp ? pat[ph % 4] : 1'b1;
      ph++;
      if (stalled) begin
        chk("hold_valid", 64'(out_valid), 64'h1);
        chk("hold_data", out_data, h_data);
        chk("hold_pos", {32'(out_ch), 32'(out_idx)}, {h_ch[31:0], h_idx[31:0]});
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          chk("extra_word", 64'(out_valid), 64'h0);
        end else begin
          e = sb.pop_front();
          chk("data", out_data, e.d);
          chk("ch", 64'(out_ch), 64'(e.ch));
          chk("idx", 64'(out_idx), 64'(e.idx));
        end
        stalled = 1'b0;
      end else if (out_valid) begin
        stalled = 1'b1;
        h_data  = out_data;
        h_ch    = 64'(out_ch);
        h_idx   = 64'(out_idx);
      end else begin
        stalled = 1'b0;
      end
      tick();
      cyc++;
    end
    chk("drain_left", 64'(sb.size()), 64'h0);
    chk("drain_idle", 64'(out_valid), 64'h0);
    out_ready = 1'b1;
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    int seen;
    rst = 1'b1; grst = 1'b0; wr_en = 1'b0; wr_idx = '0; data_in = '0; out_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_data", out_data, 64'h0);
    chk("rst_ch", 64'(out_ch), 64'h0);
    chk("rst_idx", 64'(out_idx), 64'h0);
    chk("rst_busy", 64'(replay_busy), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);

    // Basic replay
    for (int i = 0; i < 4; i++) wr(i, 64'hA0 + 64'(i), 64'hB0 + 64'(i));
    grst = 1'b1;
    tick();
    grst = 1'b0;
    chk("lat_k_valid", 64'(out_valid), 64'h0);
    for (int i = 0; i < 4; i++) begin
      push(64'hA0 + 64'(i), 0, i);
      push(64'hB0 + 64'(i), 1, i);
    end
    tick();
    chk("lat_k1_valid", 64'(out_valid), 64'h1);
    chk("lat_k1_busy", 64'(replay_busy), 64'h1);
    drain(40, 1'b0);
    chk("basic_busy_end", 64'(replay_busy), 64'h0);

    // Sparse fill
    wr(5, 64'h55, 64'h66);
    grst = 1'b1;
    tick();
    grst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      push(64'h0, 0, i);
      push(64'h0, 1, i);
    end
    push(64'h55, 0, 5);
    push(64'h66, 1, 5);
    drain(60, 1'b0);

    // Back-pressure
    for (int i = 0; i < 3; i++) wr(i, 64'hC0 + 64'(i), 64'hD0 + 64'(i));
    grst = 1'b1;
    tick();
    grst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(64'hC0 + 64'(i), 0, i);
      push(64'hD0 + 64'(i), 1, i);
    end
    drain(60, 1'b1);
    chk("bp_overrun", 64'(overrun), 64'h0);

    // Overrun
    for (int i = 0; i < 16; i++) wr(i, 64'hE00 + 64'(i), 64'hE80 + 64'(i));
    out_ready = 1'b0;
    grst = 1'b1;
    tick();
    grst = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) wr(i, 64'hF0 + 64'(i), 64'hF8 + 64'(i));
    chk("ovr_stall_valid", 64'(out_valid), 64'h1);
    chk("ovr_stall_data", out_data, 64'hE00);
    grst = 1'b1;
    tick();
    grst = 1'b0;
    chk("ovr_valid_drop", 64'(out_valid), 64'h0);
    chk("ovr_flag", 64'(overrun), 64'h1);
    for (int i = 0; i < 3; i++) begin
      push(64'hF0 + 64'(i), 0, i);
      push(64'hF8 + 64'(i), 1, i);
    end
    tick();
    chk("ovr_restart_idx", 64'(out_idx), 64'h0);
    chk("ovr_restart_ch", 64'(out_ch), 64'h0);
    drain(40, 1'b0);
    chk("ovr_sticky", 64'(overrun), 64'h1);

    // Same-cycle write and swap
    wr_en = 1'b1; wr_idx = 4'd7; data_in = {64'h1FF, 64'hFF}; grst = 1'b1;
    tick();
    wr_en = 1'b0; grst = 1'b0;
    for (int i = 0; i < 7; i++) begin
      push(64'h0, 0, i);
      push(64'h0, 1, i);
    end
    push(64'hFF, 0, 7);
    push(64'h1FF, 1, 7);
    drain(60, 1'b0);

    // Reset mid-replay
    for (int i = 0; i < 4; i++) wr(i, 64'h700 + 64'(i), 64'h780 + 64'(i));
    grst = 1'b1;
    tick();
    grst = 1'b0;
    tick(); tick(); tick(); tick();
    chk("mid_word3_data", out_data, 64'h781);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_valid", 64'(out_valid), 64'h0);
    chk("mrst_data", out_data, 64'h0);
    chk("mrst_ch", 64'(out_ch), 64'h0);
    chk("mrst_idx", 64'(out_idx), 64'h0);
    chk("mrst_busy", 64'(replay_busy), 64'h0);
    chk("mrst_overrun", 64'(overrun), 64'h0);
    grst = 1'b1;
    tick();
    grst = 1'b0;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid || replay_busy) seen++;
      tick();
    end
    chk("empty_grst_silent", 64'(seen), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gamma_replay_buffer.md
# gamma_replay_buffer

Parametrised ping-pong replay buffer for the multiplexed column. During each gamma cycle it captures NUM_INPUTS channels of P-bit spike vectors into a write bank. On the next gamma boundary (`grst`) it swaps banks. It then replays the captured bank one P-bit word per cycle, channel-interleaved, over a valid/ready stream to the shared macro column. It adds to the previous fixed 2-channel design: arbitrary channel count, a per-entry valid map, fill tracking, back-pressure and overrun detection.

## Interface
- `NUM_INPUTS`, 2: channels multiplexed onto the output; must be ≥2.
- `BUFFER_DEPTH`, 16: entries per channel per bank; must be a power of 2, ≥2.
- `P`, 64: bits per spike vector.
- Clocking and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `grst`  in  1  gamma boundary pulse; one-cycle high per gamma cycle.
- `wr_en`  in  1  write strobe.
- `wr_idx`  in  $clog2(BUFFER_DEPTH)  entry index for the write.
- `data_in`  in  NUM_INPUTS*P  channel c occupies bits [c*P +: P].
- `out_ready`  in  1  consumer accepts the word.
- `out_valid`  out  1  `out_data`, `out_ch` and `out_idx` are valid.
- `out_data`  out  P  replayed vector.
- `out_ch`  out  $clog2(NUM_INPUTS)  channel of the current word.
- `out_idx`  out  $clog2(BUFFER_DEPTH)  entry of the current word.
- `replay_busy`  out  1  high while in REPLAY.
- `overrun`  out  1  sticky; set when `grst` arrives while in REPLAY.

## Operation
- Storage:
  - Two banks, each of NUM_INPUTS × BUFFER_DEPTH × P bits.
  - One valid bit per entry per bank.
  - A per-bank `fill` value, range 0..BUFFER_DEPTH.
  - `wsel` selects the write bank; the other bank is the read bank.
- Write:
  - When `wr_en` is high, all NUM_INPUTS words of `data_in` are stored at `wr_idx` of the write bank.
  - The entry's valid bit is set.
  - `fill` is updated to max(`fill`, `wr_idx`+1).
  - Rewriting an entry overwrites it.
- Swap, on `grst`:
  - `wsel` toggles.
  - The new write bank has its valid map and `fill` cleared.
  - The new read bank keeps its contents.
- FSM:
  - IDLE → REPLAY on `grst` when the new read bank has `fill` > 0.
  - With `fill` == 0 the FSM stays in IDLE and nothing is emitted.
  - REPLAY walks idx = 0..`fill`-1, outer loop. For each idx it walks ch = 0..NUM_INPUTS-1, inner loop.
  - REPLAY → IDLE on acceptance of (`fill`-1, NUM_INPUTS-1).
- Data rules:
  - An entry whose valid bit is clear replays as all-zero data; it is still emitted.
  - Total words per replay = `fill` × NUM_INPUTS.
- Handshake:
  - Standard valid/ready; a word is accepted when `out_valid` && `out_ready`.
  - While `out_valid` && !`out_ready`, `out_data`, `out_ch` and `out_idx` are held stable.
  - `out_valid` never drops without acceptance, except on `rst` or overrun.
- Overrun, `grst` while in REPLAY:
  - The current replay is aborted and `out_valid` drops next cycle.
  - `overrun` is set.
  - Banks swap normally, and a new replay starts from (0,0) if the new `fill` > 0.
  - `overrun` is cleared only by `rst`.
- Simultaneous `wr_en` and `grst`: the write lands in the pre-swap write bank and is included in the replay that starts.
- `rst`:
  - Clears both valid maps, both `fill` values and `wsel`.
  - Sets the FSM to IDLE.
  - Output resets: `out_valid`=0, `out_data`=0, `out_ch`=0, `out_idx`=0, `replay_busy`=0, `overrun`=0.
  - Mid-replay, `rst` aborts immediately and wins over `grst` and `wr_en`.

## Timing
- Write: data is visible in the bank the cycle after the `wr_en` edge.
- Replay start:
  - With `grst` sampled at edge k, the swap happens at edge k.
  - `replay_busy` and `out_valid` are high after edge k+1.
  - The first word, (idx 0, ch 0), is on the outputs after edge k+1.
- Throughput: one word per cycle while `out_ready` is high; outputs are registered.
- End of replay: after acceptance of the last word at edge m, `out_valid` and `replay_busy` are 0 after edge m.
- Overrun: with `grst` at edge k in REPLAY, `out_valid` is 0 after edge k, and the new replay's first word appears after edge k+1.

## Configuration
- `GAMMA_REPLAY_ZERO_SKIP_EN`
  - Defined: words whose data is all-zero (including invalid entries) are skipped internally and never presented on `out_valid`. Each skipped word costs one cycle, so `out_valid` may be low for gaps inside REPLAY. If every word is zero, REPLAY still runs `fill`×NUM_INPUTS cycles with `out_valid` low throughout.
  - Undefined: every word is emitted, as described in Operation.

## Test plan
- Basic replay:
  - Stimulus: defaults; write idx 0..3 with ch0 = 64'hA0+i and ch1 = 64'hB0+i; pulse `grst`; hold `out_ready`=1.
  - Required response: 8 words (A0,B0,A1,B1,…,A3,B3) with `out_ch` alternating 0,1 and `out_idx` 0,0,1,1,…; first word 2 edges after `grst` sampling; `replay_busy` low after the 8th.
- Sparse fill:
  - Stimulus: write only idx 5; `grst`.
  - Required response: 12 words; idx 0..4 are zero and idx 5 carries the data. With the macro defined, only the 2 idx-5 words appear.
- Back-pressure:
  - Stimulus: `out_ready` toggles 1,0,0,1 during replay.
  - Required response: outputs held stable across the low cycles, no word lost or duplicated, order unchanged.
- Overrun:
  - Stimulus: fill 16 entries; `grst`; hold `out_ready`=0; after 5 cycles pulse `grst` again with 3 entries written to the other bank.
  - Required response: `overrun`=1 sticky; `out_valid` drops one cycle; the new replay of 6 words starts from (0,0).
- Same-cycle write and swap:
  - Stimulus: `wr_en` at idx 7 with 64'hFF together with `grst`.
  - Required response: `fill`=8 and idx 7 replays 64'hFF.
- Reset mid-replay:
  - Stimulus: assert `rst` during word 3.
  - Required response: next cycle all outputs are 0; a following `grst` with no writes produces no output.
